// File: rtl/freq_div_pkg.sv
// Shared types and constants for the programmable clock-enable divider.
package freq_div_pkg;

    // Sequencer states: stopped, running, finishing the current period before stopping.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Smallest ratio that still produces a distinct high and low phase.
    localparam int DIV_MIN = 2;

endpackage

// File: rtl/freq_div_core.sv
// Period counter and waveform generator. Counts 0..N-1 while running and
// produces a registered high phase of ceil(N/2) cycles plus a tick on cnt==0.
// The ratio only changes on a wrap edge or while stopped, so the high-phase
// length can always be taken from the ratio presented on the current cycle.
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         active,
    input  logic         run,
    input  logic [W-1:0] ratio,
    output logic         wrap,
    output logic         out,
    output logic         tick
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;
    logic [W-1:0] hi_len;
    logic         out_reg;
    logic         tick_reg;

    // Last cycle of the current period.
    assign wrap   = active && (cnt_reg == ratio - 1'b1);
    // High phase length: ceil(N/2), so odd ratios get the longer high phase.
    assign hi_len = ratio - (ratio >> 1);

    // Next count: restart at zero on start or wrap, hold at zero when idle.
    always_comb begin
        cnt_next = '0;
        if (run && active && !wrap) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Register the count and decode the outputs from the next count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg  <= '0;
            out_reg  <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            out_reg  <= run && (cnt_next < hi_len);
            tick_reg <= run && (cnt_next == '0);
        end
    end

    assign out  = out_reg;
    assign tick = tick_reg;

endmodule

// File: rtl/freq_div_ctrl.sv
// Run-time programmable clock-enable divider: start/stop sequencing on en,
// ratio updates through a valid/ready port, applied only at period boundaries.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int W       = 8,
    parameter int DIV_DEF = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_ratio,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         out,
    output logic         tick,
    output logic         busy
);

    state_t       state_reg;
    logic [W-1:0] ratio_reg;
    logic [W-1:0] pend_ratio_reg;
    logic         pend_vld_reg;
    logic         cfg_err_reg;
    logic         busy_reg;

    logic         wrap;
    logic         active;
    logic         run_next;
    logic         xfer;
    logic         bad_ratio;

    assign active    = (state_reg != IDLE);
    // Keep running unless en is low when the current period ends (or we are idle).
    assign run_next  = en || (active && !wrap);
    assign cfg_ready = ~pend_vld_reg;
    assign xfer      = cfg_valid && cfg_ready;
    assign bad_ratio = (cfg_ratio < W'(DIV_MIN));

    // Sequencer, ratio/pending handshake and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            ratio_reg      <= W'(DIV_DEF);
            pend_ratio_reg <= W'(DIV_DEF);
            pend_vld_reg   <= 1'b0;
            cfg_err_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            cfg_err_reg <= xfer && bad_ratio;
            busy_reg    <= run_next;

            case (state_reg)
                IDLE: begin
                    if (en) state_reg <= RUN;
                end
                RUN: begin
                    if (!en) state_reg <= wrap ? IDLE : STOP;
                end
                STOP: begin
                    if (en)        state_reg <= RUN;
                    else if (wrap) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            if (!active) begin
                // Stopped: a leftover pending ratio (accepted on the final wrap) is
                // applied now; otherwise a valid offer is applied directly.
                if (pend_vld_reg) begin
                    ratio_reg    <= pend_ratio_reg;
                    pend_vld_reg <= 1'b0;
                end else if (xfer && !bad_ratio) begin
                    ratio_reg <= cfg_ratio;
                end
            end else begin
                // Running: hold the offer until the wrap so no period is cut short.
                if (wrap && pend_vld_reg) begin
                    ratio_reg    <= pend_ratio_reg;
                    pend_vld_reg <= 1'b0;
                end else if (xfer && !bad_ratio) begin
                    pend_ratio_reg <= cfg_ratio;
                    pend_vld_reg   <= 1'b1;
                end
            end
        end
    end

    assign cfg_err = cfg_err_reg;
    assign busy    = busy_reg;

    freq_div_core #(
        .W(W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .active(active),
        .run   (run_next),
        .ratio (ratio_reg),
        .wrap  (wrap),
        .out   (out),
        .tick  (tick)
    );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Scoreboard bench for freq_div_ctrl: a period-level reference model pushes the
// expected outputs of every cycle; an independent monitor pops and compares.
module tb_freq_div_ctrl;

    localparam int W       = 8;
    localparam int DIV_DEF = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_ratio = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         out;
    logic         tick;
    logic         busy;

    always #5 clk = ~clk;

    freq_div_ctrl #(
        .W(W),
        .DIV_DEF(DIV_DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ratio(cfg_ratio),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .out      (out),
        .tick     (tick),
        .busy     (busy)
    );

    typedef struct packed {
        logic out;
        logic tick;
        logic busy;
        logic err;
        logic ready;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a period is a list of {tick,out} pairs built from N.
    int       m_n;
    bit       m_pend;
    int       m_pend_n;
    bit       m_busy;
    bit       m_err;
    bit [1:0] per_q[$];

    task automatic check(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    function automatic void model_reset();
        m_n    = DIV_DEF;
        m_pend = 1'b0;
        m_pend_n = 0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        per_q.delete();
    endfunction

    function automatic void start_period();
        per_q.delete();
        for (int i = 0; i < m_n; i++) begin
            per_q.push_back({(i == 0), (i < (m_n + 1) / 2)});
        end
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input logic e, input logic v, input int r);
        bit last;
        bit xfer;
        bit bad;
        last  = m_busy && (per_q.size() == 1);
        xfer  = v && !m_pend;
        bad   = (r < 2);
        m_err = xfer && bad;
        if (xfer) begin
            $display("cfg transfer t=%0t ratio=%0d %s", $time, r,
                     bad ? "rejected" : (m_busy ? "pending" : "applied"));
        end
        if (!m_busy) begin
            if (m_pend) begin
                m_n = m_pend_n;
                m_pend = 1'b0;
            end else if (xfer && !bad) begin
                m_n = r;
            end
        end else begin
            if (last && m_pend) begin
                m_n = m_pend_n;
                m_pend = 1'b0;
            end else if (xfer && !bad) begin
                m_pend_n = r;
                m_pend = 1'b1;
            end
        end
        if (m_busy) begin
            void'(per_q.pop_front());
            if (per_q.size() == 0) begin
                if (e) start_period();
                else   m_busy = 1'b0;
            end
        end else if (e) begin
            m_busy = 1'b1;
            start_period();
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the edge.
    task automatic step(input logic e, input logic v, input logic [W-1:0] r);
        exp_t x;
        @(negedge clk);
        en        = e;
        cfg_valid = v;
        cfg_ratio = r;
        model_edge(e, v, int'(r));
        x.out   = m_busy ? per_q[0][0] : 1'b0;
        x.tick  = m_busy ? per_q[0][1] : 1'b0;
        x.busy  = m_busy;
        x.err   = m_err;
        x.ready = !m_pend;
        sb_q.push_back(x);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out"},   out,       1'b0);
        check({tag, "_tick"},  tick,      1'b0);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_err"},   cfg_err,   1'b0);
        check({tag, "_ready"}, cfg_ready, 1'b1);
    endtask

    // Reset in the middle of a cycle; outputs must clear without a clock edge.
    task automatic reset_mid();
        @(negedge clk);
        #2;
        rst       = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("out",       out,       e.out);
            check("tick",      tick,      e.tick);
            check("busy",      busy,      e.busy);
            check("cfg_err",   cfg_err,   e.err);
            check("cfg_ready", cfg_ready, e.ready);
        end
    end

    initial begin
        logic         e_r;
        logic [W-1:0] r_r;
        model_reset();

        // Power-up reset.
        #2 rst = 1'b0;
        #1 check_reset_values("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Default ratio 5: 1,1,1,0,0 with a tick every 5 cycles.
        repeat (16) step(1, 0, '0);

        // Offer 4 mid-period, keep a further offer waiting while one is pending.
        step(1, 1, 8'd4);
        step(1, 1, 8'd9);
        step(1, 1, 8'd9);
        repeat (4) step(1, 0, '0);
        step(1, 1, 8'd4);
        repeat (14) step(1, 0, '0);

        // Illegal ratios are rejected with an error pulse.
        step(1, 1, 8'd1);
        repeat (3) step(1, 0, '0);
        step(1, 1, 8'd0);
        repeat (6) step(1, 0, '0);

        // Ratio 6: drop en at cnt=1, finish the period, go idle.
        repeat (12) step(0, 0, '0);
        step(0, 1, 8'd6);
        step(1, 0, '0);
        step(1, 0, '0);
        repeat (9) step(0, 0, '0);
        // Restart, then drop en briefly and re-raise it before the period ends.
        repeat (3) step(1, 0, '0);
        repeat (2) step(0, 0, '0);
        repeat (14) step(1, 0, '0);

        // Reset with a pending ratio of 7; the restart must use the default ratio.
        step(1, 1, 8'd7);
        step(1, 0, '0);
        reset_mid();
        repeat (12) step(1, 0, '0);

        // Extreme ratios: 2 and 255.
        repeat (12) step(0, 0, '0);
        step(0, 1, 8'd2);
        repeat (10) step(1, 0, '0);
        step(1, 1, 8'd255);
        repeat (600) step(1, 0, '0);

        // Randomized run mixing start/stop and config offers.
        e_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) e_r = ~e_r;
            if ($urandom_range(0, 3) == 0) r_r = W'($urandom_range(0, 3));
            else                           r_r = W'($urandom_range(0, 40));
            step(e_r, ($urandom_range(0, 9) == 0), r_r);
            if (i == 2000) reset_mid();
        end
        step(0, 0, '0);

        @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
